// File: rtl/ctrl_pkg.sv
// Decoded control bundle layout shared by the decoder-to-writeback control pipeline.
// The all-zero bundle is the safe default: no memory write, no register write.
package ctrl_pkg;

  localparam int unsigned ALU_OP_W      = 4;
  localparam int unsigned ALU_SRCA_W    = 2;
  localparam int unsigned IMMG_OP_W     = 3;
  localparam int unsigned MEM_D_WDSRC_W = 2;
  localparam int unsigned DATAOUT_SRC_W = 2;
  localparam int unsigned BJ_OP_W       = 3;

  typedef struct packed {
    logic [ALU_OP_W-1:0]      alu_op;
    logic [ALU_SRCA_W-1:0]    alu_srca;
    logic [IMMG_OP_W-1:0]     immg_op;
    logic [MEM_D_WDSRC_W-1:0] mem_d_wdsrc;
    logic                     mem_d_we;
    logic [DATAOUT_SRC_W-1:0] dataout_src;
    logic                     reg_we;
    logic [BJ_OP_W-1:0]       bj_op;
  } ctrl_t;

  localparam int unsigned CTRL_W       = $bits(ctrl_t);
  localparam ctrl_t       CTRL_DEFAULT = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Handshake, per-stage control and tap bus of ctrl_pipe.
// master = decoder/consumer side, slave = the pipeline itself.
interface ctrl_pipe_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W
);

  logic [CTRL_W-1:0]        in_ctrl;
  logic                     in_valid;
  logic                     in_ready;
  logic [STAGES-1:0]        stall;
  logic [STAGES-1:0]        flush;
  logic                     out_ready;
  logic [STAGES*CTRL_W-1:0] tap_ctrl;
  logic [STAGES-1:0]        tap_valid;

  modport master (
    output in_ctrl, in_valid, stall, flush, out_ready,
    input  in_ready, tap_ctrl, tap_valid
  );

  modport slave (
    input  in_ctrl, in_valid, stall, flush, out_ready,
    output in_ready, tap_ctrl, tap_valid
  );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: flush beats hold, hold beats load.
// A held source yields a bubble so a bundle is never duplicated.
module ctrl_pipe_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_src_valid,
  input  logic              i_src_hold,
  input  logic [CTRL_W-1:0] i_src_ctrl,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_load;

  assign w_load = i_src_valid & ~i_src_hold;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_W'(CTRL_DEFAULT);
    end else if (!i_hold) begin
      r_valid <= w_load;
      // Empty stages carry the default bundle so no stray write enable leaks out.
      r_ctrl  <= w_load ? i_src_ctrl : CTRL_W'(CTRL_DEFAULT);
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/ctrl_pipe.sv
// Multi-stage carrier for the decoded control bundle with valid/ready, stall, flush and
// bubble collapse. Optional perf counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);

  logic [STAGES-1:0]        w_hold;
  logic [STAGES-1:0]        w_valid;
  logic [STAGES*CTRL_W-1:0] w_ctrl;

  // An empty stage never forwards back-pressure, so bubbles get squeezed out.
  always_comb begin
    w_hold             = '0;
    w_hold[STAGES-1]   = bus.stall[STAGES-1] | ~bus.out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_hold[k] = bus.stall[k] | (w_valid[k] & w_hold[k+1]);
    end
  end

  assign bus.in_ready = ~w_hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              w_src_valid;
    logic              w_src_hold;
    logic [CTRL_W-1:0] w_src_ctrl;

    if (k == 0) begin : g_head
      assign w_src_valid = bus.in_valid;
      assign w_src_hold  = 1'b0;
      assign w_src_ctrl  = bus.in_ctrl;
    end else begin : g_body
      assign w_src_valid = w_valid[k-1];
      assign w_src_hold  = w_hold[k-1];
      assign w_src_ctrl  = w_ctrl[(k-1)*CTRL_W +: CTRL_W];
    end

    ctrl_pipe_stage #(
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (bus.flush[k]),
      .i_hold      (w_hold[k]),
      .i_src_valid (w_src_valid),
      .i_src_hold  (w_src_hold),
      .i_src_ctrl  (w_src_ctrl),
      .o_valid     (w_valid[k]),
      .o_ctrl      (w_ctrl[k*CTRL_W +: CTRL_W])
    );
  end

  assign bus.tap_valid = w_valid;
  assign bus.tap_ctrl  = w_ctrl;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (!w_valid[STAGES-1] && bus.out_ready && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
      if ((|bus.flush) && (r_perf_flushes != 32'hFFFF_FFFF)) begin
        r_perf_flushes <= r_perf_flushes + 32'd1;
      end
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (STAGES=3): reset, streaming, stall/bubble collapse,
// flush priority, back-pressure and, with CTRL_PIPE_PERF_EN, the perf counters.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int unsigned S = 3;
  localparam int unsigned W = CTRL_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.STAGES(S), .CTRL_W(W)) bus ();

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  ctrl_pipe #(
    .STAGES (S),
    .CTRL_W (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_bubbles (perf_bubbles),
    .perf_flushes (perf_flushes)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stage(input string tag, input int k, input logic v, input logic [W-1:0] c);
    chk({tag, ".valid"}, 64'(bus.tap_valid[k]), 64'(v));
    chk({tag, ".ctrl"}, 64'(bus.tap_ctrl[k*W +: W]), 64'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.stall     = '0;
    bus.flush     = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  ctrl_t b_we;

  initial begin
    // Reset with a valid all-ones bundle offered: nothing may be captured.
    idle_inputs();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = '1;
    tick();
    tick();
    chk("rst.tap_valid", 64'(bus.tap_valid), 64'h0);
    chk("rst.tap_ctrl", 64'(bus.tap_ctrl), 64'h0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'h1);
    rst         = 1'b0;
    bus.in_ctrl = 18'h11;
    tick();
    chk_stage("rst.first_s0", 0, 1'b1, 18'h11);
    chk("rst.first_tv", 64'(bus.tap_valid), 64'h1);

    // Streaming 0x11, 0x22, 0x33 back to back.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h11;
    #1 chk("str.in_ready0", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_ctrl = 18'h22;
    #1 chk("str.in_ready1", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("str.e2_s1", 1, 1'b1, 18'h11);
    chk_stage("str.e2_s0", 0, 1'b1, 18'h22);
    bus.in_ctrl = 18'h33;
    #1 chk("str.in_ready2", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("str.e3_s2", 2, 1'b1, 18'h11);
    chk_stage("str.e3_s1", 1, 1'b1, 18'h22);
    chk_stage("str.e3_s0", 0, 1'b1, 18'h33);
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    tick();
    chk_stage("str.e4_s2", 2, 1'b1, 18'h22);
    chk_stage("str.e4_s0", 0, 1'b0, 18'h0);
    tick();
    chk_stage("str.e5_s2", 2, 1'b1, 18'h33);
    chk("str.e5_tv", 64'(bus.tap_valid), 64'h4);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h44;
    tick();
    chk("str.e6_tv", 64'(bus.tap_valid), 64'h1);
    // Reset in flight discards everything.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("str.midrst_tv", 64'(bus.tap_valid), 64'h0);
    chk("str.midrst_tc", 64'(bus.tap_ctrl), 64'h0);

    // Stall on stage 1 with stage 2 empty: bubbles go downstream, stage 0 fills first.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h05;
    tick();
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    tick();
    chk("stl.setup_tv", 64'(bus.tap_valid), 64'h2);
    bus.stall    = 3'b010;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h06;
    #1 chk("stl.in_ready_a", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("stl.c1_s2", 2, 1'b0, 18'h0);
    chk_stage("stl.c1_s1", 1, 1'b1, 18'h05);
    chk_stage("stl.c1_s0", 0, 1'b1, 18'h06);
    bus.in_ctrl = 18'h07;
    #1 chk("stl.in_ready_b", 64'(bus.in_ready), 64'h0);
    tick();
    chk("stl.c2_tv", 64'(bus.tap_valid), 64'h3);
    chk_stage("stl.c2_s0", 0, 1'b1, 18'h06);
    bus.stall = '0;
    #1 chk("stl.in_ready_c", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("stl.rel_s2", 2, 1'b1, 18'h05);
    chk_stage("stl.rel_s1", 1, 1'b1, 18'h06);
    chk_stage("stl.rel_s0", 0, 1'b1, 18'h07);
    bus.in_valid = 1'b0;

    // Flush and stall together on stage 1: flush wins, hold chain still holds stage 0.
    do_reset();
    b_we          = '0;
    b_we.alu_op   = 4'h3;
    b_we.mem_d_we = 1'b1;
    b_we.reg_we   = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = b_we;
    tick();
    bus.in_ctrl = 18'h0A;
    tick();
    chk_stage("fl.setup_s1", 1, 1'b1, b_we);
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    bus.stall    = 3'b010;
    bus.flush    = 3'b010;
    #1 chk("fl.in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    chk_stage("fl.s1", 1, 1'b0, 18'h0);
    chk_stage("fl.s0", 0, 1'b1, 18'h0A);
    chk_stage("fl.s2", 2, 1'b0, 18'h0);
    bus.stall = '0;
    bus.flush = '0;
    tick();
    tick();
    chk_stage("fl.after_s2", 2, 1'b1, 18'h0A);
    // Accepted input with flush[0]: consumed and dropped.
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h3C;
    bus.flush    = 3'b001;
    #1 chk("fl0.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("fl0.s0", 0, 1'b0, 18'h0);
    idle_inputs();

    // Back-pressure: three bundles parked, the fourth waits, none lost or repeated.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 18'h01;
    tick();
    bus.in_ctrl = 18'h02;
    tick();
    bus.in_ctrl = 18'h03;
    tick();
    bus.out_ready = 1'b0;
    bus.in_ctrl   = 18'h04;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp.in_ready", 64'(bus.in_ready), 64'h0);
      tick();
      chk("bp.tv", 64'(bus.tap_valid), 64'h7);
      chk("bp.tc", 64'(bus.tap_ctrl), {10'h0, 18'h01, 18'h02, 18'h03});
    end
    bus.out_ready = 1'b1;
    #1 chk("bp.in_ready_back", 64'(bus.in_ready), 64'h1);
    tick();
    chk_stage("bp.d1", 2, 1'b1, 18'h02);
    chk_stage("bp.d1_s0", 0, 1'b1, 18'h04);
    bus.in_ctrl = 18'h05;
    tick();
    chk_stage("bp.d2", 2, 1'b1, 18'h03);
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    tick();
    chk_stage("bp.d3", 2, 1'b1, 18'h04);
    tick();
    chk_stage("bp.d4", 2, 1'b1, 18'h05);
    tick();
    chk("bp.drained", 64'(bus.tap_valid), 64'h0);

`ifdef CTRL_PIPE_PERF_EN
    do_reset();
    chk("perf.rst_b", 64'(perf_bubbles), 64'h0);
    chk("perf.rst_f", 64'(perf_flushes), 64'h0);
    repeat (10) tick();
    chk("perf.bubbles10", 64'(perf_bubbles), 64'd10);
    bus.out_ready = 1'b0;
    bus.flush     = 3'b001;
    tick();
    bus.flush = '0;
    tick();
    bus.flush = 3'b001;
    tick();
    bus.flush = '0;
    tick();
    chk("perf.flushes2", 64'(perf_flushes), 64'd2);
    chk("perf.bubbles_frozen", 64'(perf_bubbles), 64'd10);
    bus.out_ready          = 1'b1;
    dut.r_perf_bubbles     = 32'hFFFF_FFFE;
    tick();
    chk("perf.sat1", 64'(perf_bubbles), 64'hFFFF_FFFF);
    repeat (4) tick();
    chk("perf.sat5", 64'(perf_bubbles), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
